// File: rtl/dpram_fifo_ctrl_if.sv
// dpram_fifo_ctrl_if: producer/consumer handshake plus RAM port bundle of the FIFO controller
interface dpram_fifo_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic          flush;
  logic          clr_err;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] ram_data_a;
  logic [AW-1:0] ram_ad_a;
  logic          ram_wre_a;
  logic [AW-1:0] ram_ad_b;
  logic          ram_wre_b;
  logic [DW-1:0] ram_q_b;
  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err, ram_q_b,
    output rd_data, rd_valid, full, almost_full, empty, count, overflow, underflow,
           ram_data_a, ram_ad_a, ram_wre_a, ram_ad_b, ram_wre_b
  );
  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err, ram_q_b,
    input  rd_data, rd_valid, full, almost_full, empty, count, overflow, underflow,
           ram_data_a, ram_ad_a, ram_wre_a, ram_ad_b, ram_wre_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: pointer/flag controller turning a 64x8 dual-port RAM into a synchronous FIFO
module dpram_fifo_ctrl #(
  parameter int DW        = 8,
  parameter int AW        = 6,
  parameter int AF_MARGIN = 4
) (
  input logic              clk,
  input logic              rst,
  dpram_fifo_ctrl_if.slave bus
);
  localparam logic [AW:0] DEPTH  = (AW+1)'(2**AW);
  localparam logic [AW:0] AF_LVL = (AW+1)'(2**AW - AF_MARGIN);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic          vld_q, vld_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          push_ok, pop_ok;
  logic [DW-1:0] q_b;
  // rst is kept out of the flop inputs; reset already forces the state, only the RAM strobe needs it
  always_comb begin
    push_ok = bus.wr_en & ~full_q & ~bus.flush;
    pop_ok  = bus.rd_en & ~empty_q & ~bus.flush;
    wptr_d  = bus.flush ? '0 : wptr_q + AW'(push_ok);
    rptr_d  = bus.flush ? '0 : rptr_q + AW'(pop_ok);
    cnt_d   = bus.flush ? '0 :
              (push_ok & ~pop_ok) ? cnt_q + 1'b1 :
              (pop_ok & ~push_ok) ? cnt_q - 1'b1 : cnt_q;
    full_d  = cnt_d == DEPTH;
    empty_d = cnt_d == '0;
    af_d    = cnt_d >= AF_LVL;
    vld_d   = pop_ok;
    ovf_d   = (bus.wr_en & full_q & ~bus.flush) | (ovf_q & ~bus.clr_err);
    udf_d   = (bus.rd_en & empty_q & ~bus.flush) | (udf_q & ~bus.clr_err);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  assign q_b             = bus.ram_q_b;
  assign bus.rd_data     = q_b;
  assign bus.rd_valid    = vld_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.empty       = empty_q;
  assign bus.count       = cnt_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;
  assign bus.ram_data_a  = bus.wr_data;
  assign bus.ram_ad_a    = wptr_q;
  assign bus.ram_wre_a   = push_ok & ~rst;
  assign bus.ram_ad_b    = rptr_q;
  assign bus.ram_wre_b   = 1'b0;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: directed bench with a RAM model and a queue of expected FIFO contents
module tb_dpram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] mem [64];
  logic [7:0] exp_q [$];
  dpram_fifo_ctrl_if #(.DW(8), .AW(6)) bus ();
  dpram_fifo_ctrl #(.DW(8), .AW(6), .AF_MARGIN(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (bus.ram_wre_a) mem[bus.ram_ad_a] <= bus.ram_data_a;
    if (!bus.ram_wre_b) bus.ram_q_b <= mem[bus.ram_ad_b];
  end
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic push(input logic [7:0] v);
    bus.wr_en = 1'b1;
    bus.wr_data = v;
    step();
    bus.wr_en = 1'b0;
    exp_q.push_back(v);
  endtask
  task automatic pop_chk(input string tag);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check({tag, "_vld"}, int'(bus.rd_valid), 1);
    check({tag, "_data"}, int'(bus.rd_data), int'(exp_q.pop_front()));
  endtask
  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.rd_en = 0; bus.flush = 0; bus.clr_err = 0;
    @(negedge clk);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_count", int'(bus.count), 0);
    check("rst_wre_a", int'(bus.ram_wre_a), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_empty", int'(bus.empty), 1);
      check("idle_count", int'(bus.count), 0);
      check("idle_vld", int'(bus.rd_valid), 0);
      check("idle_wre_a", int'(bus.ram_wre_a), 0);
    end
    push(8'h11); push(8'h22); push(8'h33);
    check("three_count", int'(bus.count), 3);
    check("three_empty", int'(bus.empty), 0);
    for (int i = 0; i < 3; i++) pop_chk("three_pop");
    check("three_count0", int'(bus.count), 0);
    check("three_empty1", int'(bus.empty), 1);
    step();
    check("three_vld_off", int'(bus.rd_valid), 0);
    for (int i = 0; i < 64; i++) begin
      push(8'(i * 3 + 1));
      if (i == 58) check("af_59", int'(bus.almost_full), 0);
      if (i == 59) check("af_60", int'(bus.almost_full), 1);
      if (i == 62) check("full_63", int'(bus.full), 0);
    end
    check("full_64", int'(bus.full), 1);
    check("count_64", int'(bus.count), 64);
    bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
    #1 check("ovf_wre_a", int'(bus.ram_wre_a), 0);
    step();
    bus.wr_en = 1'b0;
    check("ovf_set", int'(bus.overflow), 1);
    check("ovf_count", int'(bus.count), 64);
    for (int i = 0; i < 64; i++) pop_chk("fill_pop");
    check("fill_empty", int'(bus.empty), 1);
    check("fill_full", int'(bus.full), 0);
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    check("ovf_clr", int'(bus.overflow), 0);
    for (int i = 0; i < 10; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'(8'hC0 + i);
      step();
      check("both_vld", int'(bus.rd_valid), 1);
      check("both_data", int'(bus.rd_data), int'(exp_q.pop_front()));
      exp_q.push_back(8'(8'hC0 + i));
      check("both_count", int'(bus.count), 10);
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    for (int i = 0; i < 10; i++) pop_chk("drain_pop");
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    check("udf_set", int'(bus.underflow), 1);
    check("udf_vld", int'(bus.rd_valid), 0);
    bus.clr_err = 1'b1; step();
    check("udf_clr", int'(bus.underflow), 0);
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    check("udf_win", int'(bus.underflow), 1);
    bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
    check("pre_flush_cnt", int'(bus.count), 5);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wr_data = 8'h99;
    #1 check("flush_wre_a", int'(bus.ram_wre_a), 0);
    step();
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    exp_q.delete();
    check("flush_count", int'(bus.count), 0);
    check("flush_empty", int'(bus.empty), 1);
    check("flush_vld", int'(bus.rd_valid), 0);
    check("flush_af", int'(bus.almost_full), 0);
    check("flush_udf", int'(bus.underflow), 0);
    push(8'h61); push(8'h62);
    pop_chk("post_flush_pop");
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    bus.rd_en = 1'b1; step(); bus.rd_en = 1'b0;
    check("pre_rst_udf", int'(bus.underflow), 1);
    push(8'h71); push(8'h72); push(8'h73);
    bus.wr_en = 1'b1; bus.wr_data = 8'h74;
    #2 rst = 1'b1;
    #1;
    check("arst_count", int'(bus.count), 0);
    check("arst_empty", int'(bus.empty), 1);
    check("arst_udf", int'(bus.underflow), 0);
    check("arst_wre_a", int'(bus.ram_wre_a), 0);
    check("arst_ad_a", int'(bus.ram_ad_a), 0);
    step();
    check("arst_hold", int'(bus.count), 0);
    bus.wr_en = 1'b0;
    rst = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
